// File: rtl/switch_box_cfg.sv
// Wilton switch box for one routing tile, configured through a serial scan chain into a shadow register.
// Define SWITCH_BOX_CFG_REGOUT_EN to register all routed data outputs (one cycle of latency).
module switch_box_cfg #(
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned LE_IN  = 2,
   parameter int unsigned LE_OUT = 8
) (
   input  logic              clock,
   input  logic              nreset,
   input  logic [WIDTH-1:0]  data_north_in,
   input  logic [WIDTH-1:0]  data_east_in,
   input  logic [WIDTH-1:0]  data_south_in,
   input  logic [WIDTH-1:0]  data_west_in,
   output logic [WIDTH-1:0]  data_north_out,
   output logic [WIDTH-1:0]  data_east_out,
   output logic [WIDTH-1:0]  data_south_out,
   output logic [WIDTH-1:0]  data_west_out,
   input  logic [LE_IN-1:0]  data_from_les,
   output logic [LE_OUT-1:0] data_to_les,
   input  logic              config_en,
   input  logic              config_in,
   output logic              config_out,
   output logic              configured,
   output logic              config_error
);

   localparam int unsigned NSB     = 3 + LE_IN;
   localparam int unsigned NLE     = 4 * WIDTH + LE_IN;
   localparam int unsigned SB_SEL  = $clog2(NSB);
   localparam int unsigned LE_SEL  = $clog2(NLE);
   localparam int unsigned SB_N    = 2 ** SB_SEL;
   localparam int unsigned LE_N    = 2 ** LE_SEL;
   localparam int unsigned SB_BITS = 4 * WIDTH * SB_SEL;
   localparam int unsigned CW      = SB_BITS + LE_OUT * LE_SEL;
   localparam int unsigned CNT_W   = $clog2(CW + 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT,
      ST_ABORT,
      ST_RUN
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     shadow_q;
   logic [CW-1:0]     active_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              configured_q;
   logic              error_q;

   // Load controller: only a load of exactly CW bits reaches the active register.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q      <= ST_IDLE;
         shadow_q     <= '0;
         active_q     <= '0;
         cnt_q        <= '0;
         configured_q <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_RUN: begin
               if (config_en) begin
                  state_q  <= ST_SHIFT;
                  shadow_q <= {config_in, shadow_q[CW-1:1]};
                  cnt_q    <= CNT_W'(1);
                  error_q  <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (config_en) begin
                  shadow_q <= {config_in, shadow_q[CW-1:1]};
                  if (cnt_q <= CNT_W'(CW)) cnt_q <= cnt_q + CNT_W'(1);
               end else begin
                  state_q <= (cnt_q == CNT_W'(CW)) ? ST_COMMIT : ST_ABORT;
               end
            end
            ST_COMMIT: begin
               active_q     <= shadow_q;
               configured_q <= 1'b1;
               state_q      <= ST_RUN;
            end
            ST_ABORT: begin
               error_q <= 1'b1;
               state_q <= configured_q ? ST_RUN : ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign config_out   = shadow_q[0];
   assign configured   = configured_q;
   assign config_error = error_q;

   logic [3:0][WIDTH-1:0] side_in;
   logic [3:0][WIDTH-1:0] side_mux_c;
   logic [LE_OUT-1:0]     le_mux_c;
   logic [NLE-1:0]        le_vec;
   logic [LE_N-1:0]       le_pad;

   assign side_in = {data_west_in, data_south_in, data_east_in, data_north_in};
   assign le_vec  = {data_north_in, data_east_in, data_south_in, data_west_in, data_from_les};
   assign le_pad  = LE_N'(le_vec);

   // Wilton side muxes; zero-padding the candidate vector makes out-of-range selects read 0.
   for (genvar s = 0; s < 4; s++) begin : g_side
      localparam int unsigned SA = (s == 0 || s == 2) ? 1 : 0;
      localparam int unsigned SB = (s == 0) ? 2 : (s == 1) ? 3 : (s == 2) ? 0 : 1;
      localparam int unsigned SC = (s == 0 || s == 2) ? 3 : 2;
      for (genvar i = 0; i < WIDTH; i++) begin : g_trk
         localparam int unsigned IA   = (s < 2) ? (WIDTH - i) % WIDTH : (i + 1) % WIDTH;
         localparam int unsigned IC   = (s < 2) ? (i + 1) % WIDTH : (2 * WIDTH - 2 - i) % WIDTH;
         localparam int unsigned BASE = (s * WIDTH + i) * SB_SEL;
         logic [NSB-1:0]  vec;
         logic [SB_N-1:0] pad;
         assign vec = {side_in[SC][IC], side_in[SB][i], side_in[SA][IA], data_from_les};
         assign pad = SB_N'(vec);
         assign side_mux_c[s][i] = pad[active_q[BASE +: SB_SEL]];
      end
   end

   for (genvar m = 0; m < LE_OUT; m++) begin : g_le
      assign le_mux_c[m] = le_pad[active_q[SB_BITS + m * LE_SEL +: LE_SEL]];
   end

   logic [3:0][WIDTH-1:0] side_gated_c;
   logic [LE_OUT-1:0]     le_gated_c;

   assign side_gated_c = configured_q ? side_mux_c : '0;
   assign le_gated_c   = configured_q ? le_mux_c   : '0;

`ifdef SWITCH_BOX_CFG_REGOUT_EN
   logic [3:0][WIDTH-1:0] side_out_q;
   logic [LE_OUT-1:0]     le_out_q;

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         side_out_q <= '0;
         le_out_q   <= '0;
      end else begin
         side_out_q <= side_gated_c;
         le_out_q   <= le_gated_c;
      end
   end

   assign data_north_out = side_out_q[0];
   assign data_east_out  = side_out_q[1];
   assign data_south_out = side_out_q[2];
   assign data_west_out  = side_out_q[3];
   assign data_to_les    = le_out_q;
`else
   assign data_north_out = side_gated_c[0];
   assign data_east_out  = side_gated_c[1];
   assign data_south_out = side_gated_c[2];
   assign data_west_out  = side_gated_c[3];
   assign data_to_les    = le_gated_c;
`endif

endmodule
